wb_history: RTL and testbench
=============================

Name: wb_history

Overview:
Parametrised writeback-history buffer for the pipelined LC-3b datapath. It retains the last DEPTH writeback (register select, value) pairs in age order, each with a valid bit. It serves NUM_RD combinational forwarding lookups that return the youngest matching value. It replaces fixed two-deep retention and adds bubble tracking, occupancy, flush and same-cycle bypass.

Parameters:
WIDTH, 16, data width of a retained writeback value
SEL_W, 3, register-select width
DEPTH, 4, number of retained entries (>=1)
NUM_RD, 2, number of independent lookup ports
BYPASS, 1, when 1 the incoming write participates in lookup in the same cycle

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
load  in  1  advance history one slot (pipeline not stalled)
clear  in  1  synchronous flush of all valid bits
wr_valid  in  1  incoming writeback actually writes the register file
wr_sel  in  SEL_W  incoming destination register
wr_data  in  WIDTH  incoming writeback value
rd_sel  in  NUM_RD*SEL_W  lookup register per port (port k at [k*SEL_W +: SEL_W])
hit  out  NUM_RD  lookup k matched a valid entry
hit_data  out  NUM_RD*WIDTH  value of youngest match (0 when no hit)
hit_age  out  NUM_RD*$clog2(DEPTH+1)  0 = bypassed incoming write, i+1 = entry i
ent_valid  out  DEPTH  valid bit per entry, entry 0 youngest
ent_sel  out  DEPTH*SEL_W  retained selects
ent_data  out  DEPTH*WIDTH  retained values
count  out  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset (rst_n low, async): all ent_valid, ent_sel, ent_data and count are 0. The lookup outputs therefore read hit=0, hit_data=0, hit_age=0.
- Registered state is DEPTH entries {valid, sel, data} plus count. All state updates occur on the rising clk edge.
- load=1, clear=0:
  - entry0 <= {wr_valid, wr_sel, wr_data}.
  - entry i <= entry i-1 for 0 < i < DEPTH.
  - The oldest entry is discarded.
  - wr_valid=0 inserts a bubble: valid=0, but sel and data are still captured.
- load=0, clear=0: all state holds (stall). wr_* is ignored for state.
- clear=1: all valid bits go to 0 and count goes to 0. clear beats load, so the same-cycle incoming write is dropped. sel and data hold.
- count tracking:
  - Next count = count + wr_valid - ent_valid[DEPTH-1] on load, saturating within 0..DEPTH.
  - count must always equal popcount(ent_valid); the bench asserts this every cycle.
- Lookup (combinational, per port k):
  - Candidates in priority order:
    1. The incoming write, only if BYPASS=1, load=1, clear=0, wr_valid=1 and wr_sel==rd_sel[k].
    2. Entry 0 through entry DEPTH-1, where the entry has valid=1 and sel==rd_sel[k].
  - The first candidate wins and drives hit=1, hit_data and hit_age.
  - No candidate gives hit=0, hit_data=0, hit_age=0.
  - Duplicate selects in history are legal. The youngest always wins.
- Latency: a write is visible in entry 0 one cycle after the load edge. With BYPASS=1 it is visible via lookup in the same cycle, with age 0.
- DEPTH=1: no shifting. Entry 0 is simply overwritten on load.
- Reset mid-operation: async reset dominates clear and load immediately.
- No handshake: the caller owns stall semantics via load.

Decomposition:
- Shared package lc3b_types gains:
  - constants WB_HIST_DEPTH=4 and WB_HIST_RD=2 as the system-level defaults;
  - a function wb_age_w(depth) returning $clog2(depth+1).
- One sub-module, wb_match_prio, is instantiated NUM_RD times. Given the candidate vectors (valid, sel, data) and rd_sel, it performs the youngest-first priority match and returns hit, data and age.
- The shift and count logic stays in wb_history.

Test Plan:
1. Reset, then load three writes (R1=0x1111, R2=0x2222, R3=0x3333) -> count=3. rd_sel R1 gives hit=1, data 0x1111, age 3. rd_sel R5 gives hit=0, data 0.
2. Overwrite priority: load R2=0xAAAA then R2=0xBBBB -> lookup R2 returns 0xBBBB, age 1. After three bubble loads the 0xBBBB entry is still present, and lookup returns 0xBBBB, age 4.
3. Wrap-around with DEPTH=4: five valid loads R0..R4 -> R0 is evicted, lookup R0 gives hit=0, count stays 4.
4. Bypass: load=1, wr_valid=1, wr_sel=R6, wr_data=0x6666, with R6=0x0101 already in entry 0 -> same-cycle hit_data=0x6666, age 0. With BYPASS=0 it returns 0x0101, age 1.
5. Stall plus flush: load=0 for 3 cycles gives state unchanged. Then clear=1 with load=1, wr R7=0x7777 -> next cycle count=0, all hit=0, R7 not retained.
6. Async reset pulsed mid-cycle while count=4 -> outputs zero immediately, before the next clk edge. Normal operation resumes after rst_n deasserts.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types and system-level defaults.
// Writeback-history sizing lives here so the datapath and its users agree on it.
package lc3b_types;

  localparam int WB_HIST_DEPTH = 4;
  localparam int WB_HIST_RD    = 2;
  localparam int WB_SEL_W      = 3;
  localparam int WB_WIDTH      = 16;

  // Width of an age / occupancy field able to hold 0..depth inclusive.
  function automatic int wb_age_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wb_match_prio.sv
// Youngest-first priority match over N (valid, sel, data) candidates; candidate 0 is youngest.
// Purely combinational, zero latency; no flow control.
module wb_match_prio #(
  parameter int N     = 5,
  parameter int SEL_W = 3,
  parameter int WIDTH = 16,
  parameter int AGE_W = 3
) (
  input  logic [N-1:0]       cand_valid_i,
  input  logic [N*SEL_W-1:0] cand_sel_i,
  input  logic [N*WIDTH-1:0] cand_data_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic               hit_o,
  output logic [WIDTH-1:0]   hit_data_o,
  output logic [AGE_W-1:0]   hit_age_o
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    hit_age_o  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand_valid_i[i] && (cand_sel_i[i*SEL_W +: SEL_W] == rd_sel_i)) begin
        hit_o      = 1'b1;
        hit_data_o = cand_data_i[i*WIDTH +: WIDTH];
        hit_age_o  = AGE_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_history.sv
// Age-ordered history of the last DEPTH writebacks with NUM_RD youngest-match forwarding lookups.
// Entry 0 updates one cycle after a load edge (same-cycle bypass optional); load=0 stalls, no handshake.
module wb_history
  import lc3b_types::*;
#(
  parameter int WIDTH  = WB_WIDTH,
  parameter int SEL_W  = WB_SEL_W,
  parameter int DEPTH  = WB_HIST_DEPTH,
  parameter int NUM_RD = WB_HIST_RD,
  parameter int BYPASS = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load,
  input  logic                               clear,
  input  logic                               wr_valid,
  input  logic [SEL_W-1:0]                   wr_sel,
  input  logic [WIDTH-1:0]                   wr_data,
  input  logic [NUM_RD*SEL_W-1:0]            rd_sel,
  output logic [NUM_RD-1:0]                  hit,
  output logic [NUM_RD*WIDTH-1:0]            hit_data,
  output logic [NUM_RD*$clog2(DEPTH+1)-1:0]  hit_age,
  output logic [DEPTH-1:0]                   ent_valid,
  output logic [DEPTH*SEL_W-1:0]             ent_sel,
  output logic [DEPTH*WIDTH-1:0]             ent_data,
  output logic [$clog2(DEPTH+1)-1:0]         count
);

  localparam int AGE_W = wb_age_w(DEPTH);

  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [DEPTH*SEL_W-1:0] sel_q,   sel_d;
  logic [DEPTH*WIDTH-1:0] data_q,  data_d;
  logic [AGE_W-1:0]       count_q, count_d;

  always_comb begin
    valid_d = valid_q;
    sel_d   = sel_q;
    data_d  = data_q;
    count_d = count_q;
    if (clear) begin
      // Flush drops validity only; sel/data are left as-is.
      valid_d = '0;
      count_d = '0;
    end else if (load) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_d[i]               = valid_q[i-1];
        sel_d[i*SEL_W +: SEL_W]  = sel_q[(i-1)*SEL_W +: SEL_W];
        data_d[i*WIDTH +: WIDTH] = data_q[(i-1)*WIDTH +: WIDTH];
      end
      valid_d[0]         = wr_valid;
      sel_d[0 +: SEL_W]  = wr_sel;
      data_d[0 +: WIDTH] = wr_data;
      if (wr_valid && !valid_q[DEPTH-1]) begin
        count_d = (count_q == AGE_W'(DEPTH)) ? count_q : count_q + AGE_W'(1);
      end else if (!wr_valid && valid_q[DEPTH-1]) begin
        count_d = (count_q == '0) ? count_q : count_q - AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign ent_valid = valid_q;
  assign ent_sel   = sel_q;
  assign ent_data  = data_q;
  assign count     = count_q;

  // Candidate 0 is the in-flight write; candidate i+1 is entry i.
  logic                       byp_vld;
  logic [DEPTH:0]             cand_valid;
  logic [(DEPTH+1)*SEL_W-1:0] cand_sel;
  logic [(DEPTH+1)*WIDTH-1:0] cand_data;

  assign byp_vld    = (BYPASS != 0) && load && !clear && wr_valid;
  assign cand_valid = {valid_q, byp_vld};
  assign cand_sel   = {sel_q, wr_sel};
  assign cand_data  = {data_q, wr_data};

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    wb_match_prio #(
      .N     (DEPTH + 1),
      .SEL_W (SEL_W),
      .WIDTH (WIDTH),
      .AGE_W (AGE_W)
    ) u_match (
      .cand_valid_i (cand_valid),
      .cand_sel_i   (cand_sel),
      .cand_data_i  (cand_data),
      .rd_sel_i     (rd_sel[k*SEL_W +: SEL_W]),
      .hit_o        (hit[k]),
      .hit_data_o   (hit_data[k*WIDTH +: WIDTH]),
      .hit_age_o    (hit_age[k*AGE_W +: AGE_W])
    );
  end

endmodule

// File: tb/tb_wb_history.sv
// Bench for wb_history: DEPTH=4, NUM_RD=2, one instance with bypass and one without.
module tb_wb_history;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic        clear;
  logic        wr_valid;
  logic [2:0]  wr_sel;
  logic [15:0] wr_data;
  logic [5:0]  rd_sel;

  logic [1:0]  hit, hit_nb;
  logic [31:0] hit_data, hit_data_nb;
  logic [5:0]  hit_age, hit_age_nb;
  logic [3:0]  ent_valid, ent_valid_nb;
  logic [11:0] ent_sel, ent_sel_nb;
  logic [63:0] ent_data, ent_data_nb;
  logic [2:0]  count, count_nb;

  wb_history #(.WIDTH(16), .SEL_W(3), .DEPTH(4), .NUM_RD(2), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .clear(clear), .wr_valid(wr_valid),
    .wr_sel(wr_sel), .wr_data(wr_data), .rd_sel(rd_sel), .hit(hit),
    .hit_data(hit_data), .hit_age(hit_age), .ent_valid(ent_valid),
    .ent_sel(ent_sel), .ent_data(ent_data), .count(count)
  );

  wb_history #(.WIDTH(16), .SEL_W(3), .DEPTH(4), .NUM_RD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .load(load), .clear(clear), .wr_valid(wr_valid),
    .wr_sel(wr_sel), .wr_data(wr_data), .rd_sel(rd_sel), .hit(hit_nb),
    .hit_data(hit_data_nb), .hit_age(hit_age_nb), .ent_valid(ent_valid_nb),
    .ent_sel(ent_sel_nb), .ent_data(ent_data_nb), .count(count_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    bit          nb;
    int          port;
    logic        hit;
    logic [15:0] data;
    logic [2:0]  age;
  } exp_t;

  exp_t sb[$];

  // Reference state model, entry 0 youngest.
  bit          m_valid [4];
  logic [2:0]  m_sel   [4];
  logic [15:0] m_data  [4];

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_sel[i]   = '0;
      m_data[i]  = '0;
    end
  endtask

  function automatic logic [19:0] observe(bit nb, int port);
    if (nb) return {hit_nb[port], hit_data_nb[port*16 +: 16], hit_age_nb[port*3 +: 3]};
    return {hit[port], hit_data[port*16 +: 16], hit_age[port*3 +: 3]};
  endfunction

  task automatic push_exp(string name, bit nb, int port, logic [2:0] sel,
                          logic h, logic [15:0] d, logic [2:0] a);
    exp_t e;
    rd_sel[port*3 +: 3] = sel;
    e.name = name; e.nb = nb; e.port = port; e.hit = h; e.data = d; e.age = a;
    sb.push_back(e);
  endtask

  task automatic drive_wr(logic v, logic [2:0] s, logic [15:0] d);
    load = 1'b1; wr_valid = v; wr_sel = s; wr_data = d;
  endtask

  task automatic idle();
    load = 1'b0; clear = 1'b0; wr_valid = 1'b0; wr_sel = '0; wr_data = '0;
  endtask

  // One clock: advance the model on the edge, then check full state of both instances.
  task automatic tick();
    logic [3:0]  mv;
    logic [11:0] ms;
    logic [63:0] md;
    logic [2:0]  mc;
    @(posedge clk);
    if (!rst_n) m_reset();
    else if (clear) begin
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    end else if (load) begin
      for (int i = 3; i > 0; i--) begin
        m_valid[i] = m_valid[i-1]; m_sel[i] = m_sel[i-1]; m_data[i] = m_data[i-1];
      end
      m_valid[0] = wr_valid; m_sel[0] = wr_sel; m_data[0] = wr_data;
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      mv[i] = m_valid[i]; ms[i*3 +: 3] = m_sel[i]; md[i*16 +: 16] = m_data[i];
    end
    mc = 3'($countones(mv));
    checks++;
    if (count !== 3'($countones(ent_valid))) begin
      errors++;
      $display("FAIL count_popcount: count=%0d popcount(ent_valid)=%0d", count, $countones(ent_valid));
    end
    checks++;
    if ({count, ent_valid, ent_sel, ent_data} !== {mc, mv, ms, md}) begin
      errors++;
      $display("FAIL state: got cnt=%0d v=%b s=%h d=%h required cnt=%0d v=%b s=%h d=%h",
               count, ent_valid, ent_sel, ent_data, mc, mv, ms, md);
    end
    checks++;
    if ({count_nb, ent_valid_nb, ent_sel_nb, ent_data_nb} !== {mc, mv, ms, md}) begin
      errors++;
      $display("FAIL state_nb: got cnt=%0d v=%b s=%h d=%h required cnt=%0d v=%b s=%h d=%h",
               count_nb, ent_valid_nb, ent_sel_nb, ent_data_nb, mc, mv, ms, md);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    logic [19:0] a;
    rst_n = 1'b0;
    idle();
    rd_sel = '0;
    m_reset();
    tick();
    tick();
    push_exp("reset_lookup0", 0, 0, 3'd0, 1'b0, 16'h0000, 3'd0);
    push_exp("reset_lookup1", 0, 1, 3'd1, 1'b0, 16'h0000, 3'd0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = observe(e.nb, e.port); checks++;
      if (a !== {e.hit, e.data, e.age}) begin
        errors++; $display("FAIL %s: got hit/data/age=%h required %h", e.name, a, {e.hit, e.data, e.age});
      end
    end
    checks++;
    if (count !== 3'd0 || ent_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_state: count=%0d ent_valid=%b required 0/0000", count, ent_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    logic [19:0] a;
    drive_wr(1'b1, 3'd1, 16'h1111); tick();
    drive_wr(1'b1, 3'd2, 16'h2222); tick();
    drive_wr(1'b1, 3'd3, 16'h3333); tick();
    idle();
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL basic_count: count=%0d required 3", count);
    end
    push_exp("basic_r1", 0, 0, 3'd1, 1'b1, 16'h1111, 3'd3);
    push_exp("basic_r5", 0, 1, 3'd5, 1'b0, 16'h0000, 3'd0);
    push_exp("basic_r1_nb", 1, 0, 3'd1, 1'b1, 16'h1111, 3'd3);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = observe(e.nb, e.port); checks++;
      if (a !== {e.hit, e.data, e.age}) begin
        errors++; $display("FAIL %s: got hit/data/age=%h required %h", e.name, a, {e.hit, e.data, e.age});
      end
    end
  endtask

  task automatic test_overwrite();
    exp_t e;
    logic [19:0] a;
    drive_wr(1'b1, 3'd2, 16'hAAAA); tick();
    drive_wr(1'b1, 3'd2, 16'hBBBB); tick();
    idle();
    push_exp("ovw_r2_young", 0, 0, 3'd2, 1'b1, 16'hBBBB, 3'd1);
    push_exp("ovw_r3", 0, 1, 3'd3, 1'b1, 16'h3333, 3'd3);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = observe(e.nb, e.port); checks++;
      if (a !== {e.hit, e.data, e.age}) begin
        errors++; $display("FAIL %s: got hit/data/age=%h required %h", e.name, a, {e.hit, e.data, e.age});
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_wr(1'b0, 3'd0, 16'h0000); tick();
    end
    idle();
    checks++;
    if (count !== 3'd1) begin
      errors++; $display("FAIL bubble_count: count=%0d required 1", count);
    end
    push_exp("bubble_r2_old", 0, 0, 3'd2, 1'b1, 16'hBBBB, 3'd4);
    push_exp("bubble_r0", 0, 1, 3'd0, 1'b0, 16'h0000, 3'd0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = observe(e.nb, e.port); checks++;
      if (a !== {e.hit, e.data, e.age}) begin
        errors++; $display("FAIL %s: got hit/data/age=%h required %h", e.name, a, {e.hit, e.data, e.age});
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [19:0] a;
    for (int i = 0; i < 5; i++) begin
      drive_wr(1'b1, 3'(i), 16'h0A00 + 16'(i)); tick();
    end
    idle();
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("FAIL wrap_count: count=%0d required 4", count);
    end
    push_exp("wrap_r0_evicted", 0, 0, 3'd0, 1'b0, 16'h0000, 3'd0);
    push_exp("wrap_r1_oldest", 0, 1, 3'd1, 1'b1, 16'h0A01, 3'd4);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = observe(e.nb, e.port); checks++;
      if (a !== {e.hit, e.data, e.age}) begin
        errors++; $display("FAIL %s: got hit/data/age=%h required %h", e.name, a, {e.hit, e.data, e.age});
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [19:0] a;
    drive_wr(1'b1, 3'd6, 16'h0101); tick();
    drive_wr(1'b1, 3'd6, 16'h6666);
    push_exp("byp_r6", 0, 0, 3'd6, 1'b1, 16'h6666, 3'd0);
    push_exp("byp_r4", 0, 1, 3'd4, 1'b1, 16'h0A04, 3'd2);
    push_exp("nobyp_r6", 1, 0, 3'd6, 1'b1, 16'h0101, 3'd1);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = observe(e.nb, e.port); checks++;
      if (a !== {e.hit, e.data, e.age}) begin
        errors++; $display("FAIL %s: got hit/data/age=%h required %h", e.name, a, {e.hit, e.data, e.age});
      end
    end
    tick();
    drive_wr(1'b0, 3'd6, 16'hFFFF);
    push_exp("byp_bubble_r6", 0, 0, 3'd6, 1'b1, 16'h6666, 3'd1);
    push_exp("nobyp_commit_r6", 1, 0, 3'd6, 1'b1, 16'h6666, 3'd1);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = observe(e.nb, e.port); checks++;
      if (a !== {e.hit, e.data, e.age}) begin
        errors++; $display("FAIL %s: got hit/data/age=%h required %h", e.name, a, {e.hit, e.data, e.age});
      end
    end
    drive_wr(1'b1, 3'd5, 16'h5555);
    clear = 1'b1;
    push_exp("byp_clear_r5", 0, 1, 3'd5, 1'b0, 16'h0000, 3'd0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = observe(e.nb, e.port); checks++;
      if (a !== {e.hit, e.data, e.age}) begin
        errors++; $display("FAIL %s: got hit/data/age=%h required %h", e.name, a, {e.hit, e.data, e.age});
      end
    end
    idle();
  endtask

  task automatic test_stall_flush();
    exp_t e;
    logic [19:0] a;
    load = 1'b0; wr_valid = 1'b1; wr_sel = 3'd7; wr_data = 16'hDEAD;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (count !== 3'd4 || ent_data[15:0] !== 16'h6666 || ent_sel[2:0] !== 3'd6) begin
      errors++;
      $display("FAIL stall_hold: count=%0d e0=%0d/%h required 4 6/6666", count, ent_sel[2:0], ent_data[15:0]);
    end
    drive_wr(1'b1, 3'd7, 16'h7777);
    clear = 1'b1;
    tick();
    idle();
    checks++;
    if (count !== 3'd0 || ent_valid !== 4'b0000) begin
      errors++; $display("FAIL flush_state: count=%0d ent_valid=%b required 0/0000", count, ent_valid);
    end
    push_exp("flush_r7", 0, 0, 3'd7, 1'b0, 16'h0000, 3'd0);
    push_exp("flush_r6", 0, 1, 3'd6, 1'b0, 16'h0000, 3'd0);
    push_exp("flush_r7_nb", 1, 0, 3'd7, 1'b0, 16'h0000, 3'd0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = observe(e.nb, e.port); checks++;
      if (a !== {e.hit, e.data, e.age}) begin
        errors++; $display("FAIL %s: got hit/data/age=%h required %h", e.name, a, {e.hit, e.data, e.age});
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [19:0] a;
    for (int i = 1; i < 5; i++) begin
      drive_wr(1'b1, 3'(i), 16'h0C00 + 16'(i)); tick();
    end
    idle();
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("FAIL prereset_count: count=%0d required 4", count);
    end
    push_exp("prereset_r1", 0, 0, 3'd1, 1'b1, 16'h0C01, 3'd4);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = observe(e.nb, e.port); checks++;
      if (a !== {e.hit, e.data, e.age}) begin
        errors++; $display("FAIL %s: got hit/data/age=%h required %h", e.name, a, {e.hit, e.data, e.age});
      end
    end
    #2;
    rst_n = 1'b0;
    m_reset();
    push_exp("async_r1", 0, 0, 3'd1, 1'b0, 16'h0000, 3'd0);
    push_exp("async_r4_nb", 1, 1, 3'd4, 1'b0, 16'h0000, 3'd0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = observe(e.nb, e.port); checks++;
      if (a !== {e.hit, e.data, e.age}) begin
        errors++; $display("FAIL %s: got hit/data/age=%h required %h", e.name, a, {e.hit, e.data, e.age});
      end
    end
    checks++;
    if (count !== 3'd0 || ent_valid !== 4'b0000 || ent_data !== 64'h0) begin
      errors++; $display("FAIL async_state: count=%0d ent_valid=%b required 0/0000", count, ent_valid);
    end
    #2;
    rst_n = 1'b1;
    drive_wr(1'b1, 3'd5, 16'h0D05); tick();
    idle();
    checks++;
    if (count !== 3'd1) begin
      errors++; $display("FAIL resume_count: count=%0d required 1", count);
    end
    push_exp("resume_r5", 0, 1, 3'd5, 1'b1, 16'h0D05, 3'd1);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = observe(e.nb, e.port); checks++;
      if (a !== {e.hit, e.data, e.age}) begin
        errors++; $display("FAIL %s: got hit/data/age=%h required %h", e.name, a, {e.hit, e.data, e.age});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overwrite();
    test_wrap();
    test_bypass();
    test_stall_flush();
    test_async_reset();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
